// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid entry.
// Define PIPE_STAGE_REG_SKID_EN for two-entry storage with a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [1:0]        r_occ;

  logic              w_m_valid_nxt;
  logic [DATA_W-1:0] w_m_data_nxt;
  logic [CTRL_W-1:0] w_m_ctrl_nxt;
  logic [1:0]        w_occ_nxt;
  logic              w_acc;
  logic              w_dlv;

  assign w_acc = in_valid & in_ready;
  assign w_dlv = r_m_valid & out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic              w_s_valid_nxt;
  logic [DATA_W-1:0] w_s_data_nxt;
  logic [CTRL_W-1:0] w_s_ctrl_nxt;

  // Only registered state gates acceptance, so out_ready never reaches in_ready.
  assign in_ready = !flush & !reset & !r_s_valid;

  always_comb begin
    w_m_valid_nxt = r_m_valid;
    w_m_data_nxt  = r_m_data;
    w_m_ctrl_nxt  = r_m_ctrl;
    w_s_valid_nxt = r_s_valid;
    w_s_data_nxt  = r_s_data;
    w_s_ctrl_nxt  = r_s_ctrl;
    if (flush) begin
      w_m_valid_nxt = 1'b0;
      w_m_ctrl_nxt  = '0;
      w_s_valid_nxt = 1'b0;
      w_s_ctrl_nxt  = '0;
    end else if (!r_m_valid) begin
      if (w_acc) begin
        w_m_valid_nxt = 1'b1;
        w_m_data_nxt  = in_data;
        w_m_ctrl_nxt  = in_ctrl;
      end
    end else if (w_dlv) begin
      if (r_s_valid) begin
        w_m_data_nxt = r_s_data;
        w_m_ctrl_nxt = r_s_ctrl;
        if (w_acc) begin
          w_s_data_nxt = in_data;
          w_s_ctrl_nxt = in_ctrl;
        end else begin
          w_s_valid_nxt = 1'b0;
          w_s_ctrl_nxt  = '0;
        end
      end else if (w_acc) begin
        w_m_data_nxt = in_data;
        w_m_ctrl_nxt = in_ctrl;
      end else begin
        w_m_valid_nxt = 1'b0;
        w_m_ctrl_nxt  = '0;
      end
    end else if (w_acc) begin
      w_s_valid_nxt = 1'b1;
      w_s_data_nxt  = in_data;
      w_s_ctrl_nxt  = in_ctrl;
    end
    w_occ_nxt = {1'b0, w_m_valid_nxt} + {1'b0, w_s_valid_nxt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
      r_s_ctrl  <= '0;
    end else begin
      r_s_valid <= w_s_valid_nxt;
      r_s_data  <= w_s_data_nxt;
      r_s_ctrl  <= w_s_ctrl_nxt;
    end
  end
`else
  assign in_ready = !flush & !reset & (!r_m_valid | out_ready);

  always_comb begin
    w_m_valid_nxt = r_m_valid;
    w_m_data_nxt  = r_m_data;
    w_m_ctrl_nxt  = r_m_ctrl;
    if (flush) begin
      w_m_valid_nxt = 1'b0;
      w_m_ctrl_nxt  = '0;
    end else if (w_acc) begin
      w_m_valid_nxt = 1'b1;
      w_m_data_nxt  = in_data;
      w_m_ctrl_nxt  = in_ctrl;
    end else if (w_dlv) begin
      w_m_valid_nxt = 1'b0;
      w_m_ctrl_nxt  = '0;
    end
    w_occ_nxt = {1'b0, w_m_valid_nxt};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_ctrl  <= '0;
      r_occ     <= 2'd0;
    end else begin
      r_m_valid <= w_m_valid_nxt;
      r_m_data  <= w_m_data_nxt;
      r_m_ctrl  <= w_m_ctrl_nxt;
      r_occ     <= w_occ_nxt;
    end
  end

  // Masking keeps out_ctrl usable as a bubble-safe enable downstream.
  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;
  assign out_ctrl  = r_m_valid ? r_m_ctrl : '0;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors plus a random soak.
// Follows PIPE_STAGE_REG_SKID_EN to select the expected storage depth.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [1:0]  occupancy;

  int n_pass  = 0;
  int n_total = 0;
  int n_deliv = 0;

  logic [71:0] sb_q[$];

  logic        prev_hold = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_ctrl;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Input side: every accepted beat becomes an expected output.
  always begin
    @(negedge clk);
    #1;
    if (!reset && in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
  end

  // Output side: compare each delivered beat against the oldest expected one.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_hold)
        chk("stable_hold", {out_valid, out_ctrl, out_data}, {1'b1, prev_ctrl, prev_data});
      if (!out_valid) chk("bubble_ctrl", {64'd0, out_ctrl}, 72'd0);
      if (out_valid && out_ready) begin
        n_deliv++;
        if (sb_q.size() == 0) chk("sb_underflow", {out_ctrl, out_data}, 72'hx);
        else chk("sb_beat", {out_ctrl, out_data}, sb_q.pop_front());
      end
    end
    if (reset || flush) sb_q.delete();
    prev_hold = out_valid & !out_ready & !flush & !reset;
    prev_data = out_data;
    prev_ctrl = out_ctrl;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'h1234; in_ctrl = 8'h3C;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready_comb", {71'd0, in_ready}, 72'd0);
    repeat (2) begin
      cyc();
      chk("rst_out_valid", {71'd0, out_valid}, 72'd0);
      chk("rst_out_data", {8'd0, out_data}, 72'd0);
      chk("rst_out_ctrl", {64'd0, out_ctrl}, 72'd0);
      chk("rst_occ", {70'd0, occupancy}, 72'd0);
      chk("rst_in_ready", {71'd0, in_ready}, 72'd0);
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", {71'd0, in_ready}, 72'd1);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_ctrl = 8'(i);
      cyc();
      chk("stream_data", {8'd0, out_data}, 72'(i));
      chk("stream_occ", {70'd0, occupancy}, 72'd1);
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_drain_occ", {70'd0, occupancy}, 72'd0);

    // Back-pressure
    in_valid = 1'b1; in_data = 64'hA; in_ctrl = 8'h01; out_ready = 1'b1;
    cyc();
    chk("bp_a", {8'd0, out_data}, 72'hA);
    out_ready = 1'b0; in_data = 64'hB; in_ctrl = 8'h02;
`ifdef PIPE_STAGE_REG_SKID_EN
    cyc();
    chk("bp_occ2", {70'd0, occupancy}, 72'd2);
    chk("bp_in_ready", {71'd0, in_ready}, 72'd0);
    chk("bp_hold_a", {8'd0, out_data}, 72'hA);
    in_data = 64'hC;
    cyc();
    chk("bp_occ2_b", {70'd0, occupancy}, 72'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("bp_b", {8'd0, out_data}, 72'hB);
    chk("bp_occ1", {70'd0, occupancy}, 72'd1);
    chk("bp_in_ready_back", {71'd0, in_ready}, 72'd1);
`else
    #1;
    chk("bp_in_ready", {71'd0, in_ready}, 72'd0);
    cyc();
    chk("bp_hold_a", {8'd0, out_data}, 72'hA);
    chk("bp_occ1", {70'd0, occupancy}, 72'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", {71'd0, in_ready}, 72'd1);
    cyc();
    chk("bp_b", {8'd0, out_data}, 72'hB);
    in_valid = 1'b0;
`endif
    cyc();
    chk("bp_drain_occ", {70'd0, occupancy}, 72'd0);

    // Flush with held entries
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11; in_ctrl = 8'hFF;
    cyc();
`ifdef PIPE_STAGE_REG_SKID_EN
    in_data = 64'h22;
    cyc();
    chk("fl_occ_full", {70'd0, occupancy}, 72'd2);
`else
    in_valid = 1'b0;
    chk("fl_occ_full", {70'd0, occupancy}, 72'd1);
`endif
    chk("fl_ctrl_held", {64'd0, out_ctrl}, 72'hFF);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h33; in_ctrl = 8'h0F;
    #1;
    chk("fl_in_ready", {71'd0, in_ready}, 72'd0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {71'd0, out_valid}, 72'd0);
    chk("fl_out_ctrl", {64'd0, out_ctrl}, 72'd0);
    chk("fl_occ", {70'd0, occupancy}, 72'd0);
    cyc();
    chk("fl_not_accepted", {71'd0, out_valid}, 72'd0);

    // Flush together with a delivery
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h66; in_ctrl = 8'h07;
    cyc();
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_dlv_empty", {70'd0, out_valid, occupancy[0]}, 72'd0);

    // Simultaneous deliver and accept
    in_valid = 1'b1; in_data = 64'h44; in_ctrl = 8'h0F;
    cyc();
    chk("sim_44", {8'd0, out_data}, 72'h44);
    in_data = 64'h55; in_ctrl = 8'hF0;
    cyc();
    chk("sim_55", {out_ctrl, out_data}, {8'hF0, 64'h55});
    chk("sim_occ", {70'd0, occupancy}, 72'd1);
    in_valid = 1'b0;
    cyc();

    // Random soak
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = {$urandom, $urandom};
      in_ctrl   = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("soak_sb_empty", 72'(sb_q.size()), 72'd0);
    chk("soak_occ", {70'd0, occupancy}, 72'd0);
    chk("soak_deliveries", {71'd0, (n_deliv > 60)}, 72'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
